// File: rtl/decode_seq.sv
// RV32I decode/sequencer: decodes inst combinationally, steps ALU, PC-update and LSU phases, raises traps.
// Latency 3 (ALU) / 4 (branch) / 5+LSU wait (load/store); holds in DONE/TRAP until compute_req drops, stalls in MEM_REQ on mem_valid.
module decode_seq #(
    parameter int DATA_WIDTH       = 32,
    parameter int ALU_CONTROL_BITS = 3,
    parameter int LOG2_REGISTERS   = 5,
    parameter int BYTE_DATA_WIDTH  = 4,
    parameter int MEM_TIMEOUT      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       inst,
    input  logic                        compute_req,
    output logic                        compute_valid,
    output logic                        branch_flag,
    output logic [DATA_WIDTH-1:0]       new_pc,
    output logic                        mem_req,
    output logic                        mem_we,
    input  logic                        mem_valid,
    output logic [BYTE_DATA_WIDTH-1:0]  mem_byte_enable,
    output logic                        load_unsigned,
    output logic [LOG2_REGISTERS-1:0]   addr_rd,
    output logic [LOG2_REGISTERS-1:0]   addr_rs1,
    output logic [LOG2_REGISTERS-1:0]   addr_rs2,
    output logic                        zero_rs1,
    output logic [1:0]                  rd_select,
    output logic                        rf_enable,
    output logic [DATA_WIDTH-1:0]       direct_store,
    input  logic                        less_comp,
    input  logic                        equal_comp,
    output logic [ALU_CONTROL_BITS-1:0] alu_control,
    output logic                        alt_flag,
    output logic                        unsigned_flag,
    output logic [DATA_WIDTH-1:0]       imm,
    output logic                        select_imm,
    output logic                        select_pc,
    input  logic [DATA_WIDTH-1:0]       q,
    output logic                        fault,
    output logic [1:0]                  fault_cause
);

    localparam logic [ALU_CONTROL_BITS-1:0] ADD_SUB_OP = 'd0;
    localparam logic [ALU_CONTROL_BITS-1:0] LLS_OP     = 'd1;
    localparam logic [ALU_CONTROL_BITS-1:0] RLS_OP     = 'd2;
    localparam logic [ALU_CONTROL_BITS-1:0] XOR_OP     = 'd3;
    localparam logic [ALU_CONTROL_BITS-1:0] OR_OP      = 'd4;
    localparam logic [ALU_CONTROL_BITS-1:0] AND_OP     = 'd5;

    localparam logic [2:0] S_WAIT      = 3'd0;
    localparam logic [2:0] S_COMPUTE   = 3'd1;
    localparam logic [2:0] S_PC_UPDATE = 3'd2;
    localparam logic [2:0] S_MEM_REQ   = 3'd3;
    localparam logic [2:0] S_MEM_VALID = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_TRAP      = 3'd6;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0]            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  compute_valid_q, compute_valid_d;
    logic                  branch_flag_q, branch_flag_d;
    logic [DATA_WIDTH-1:0] new_pc_q, new_pc_d;
    logic                  fault_q, fault_d;
    logic [1:0]            fault_cause_q, fault_cause_d;
    logic                  mv_first_q, mv_first_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
    logic is_illegal, is_slt, writes_rf, uses_imm, misaligned, taken;
    logic [BYTE_DATA_WIDTH-1:0] be_base;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_op     = (opcode == OPC_OP);

    assign is_illegal = !(is_lui || is_auipc || is_jal || is_jalr || is_branch ||
                          is_load || is_store || is_opimm || is_op);
    assign is_slt     = (is_op || is_opimm) && (funct3[2:1] == 2'b01);
    assign writes_rf  = is_op || is_opimm || is_lui || is_auipc || is_jal || is_jalr;
    assign uses_imm   = is_opimm || is_load || is_store || is_lui || is_auipc;

    assign addr_rd       = inst[11:7];
    assign addr_rs1      = inst[19:15];
    assign addr_rs2      = inst[24:20];
    assign load_unsigned = is_load && funct3[2];
    assign direct_store  = {{(DATA_WIDTH-1){1'b0}}, less_comp};

    assign alt_flag      = ((is_op || is_opimm) && funct3 == 3'b101 && inst[30]) ||
                           (is_op && funct3 == 3'b000 && inst[30]);
    assign unsigned_flag = ((is_op || is_opimm) && funct3 == 3'b011) ||
                           (is_branch && funct3[2:1] == 2'b11);

    always_comb begin
        imm = {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]};
        if (is_store)
            imm = {{(DATA_WIDTH-12){inst[31]}}, inst[31:25], inst[11:7]};
        else if (is_branch)
            imm = {{(DATA_WIDTH-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        else if (is_jal)
            imm = {{(DATA_WIDTH-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        else if (is_lui || is_auipc)
            imm = {inst[31:12], 12'b0};
    end

    // SLT/SLTU run through the ALU's add/sub path; their result comes back on less_comp.
    always_comb begin
        alu_control = ADD_SUB_OP;
        if (is_op || is_opimm) begin
            case (funct3)
                3'b001:  alu_control = LLS_OP;
                3'b100:  alu_control = XOR_OP;
                3'b101:  alu_control = RLS_OP;
                3'b110:  alu_control = OR_OP;
                3'b111:  alu_control = AND_OP;
                default: alu_control = ADD_SUB_OP;
            endcase
        end
    end

    always_comb begin
        rd_select = 2'd0;
        if (is_jal || is_jalr)
            rd_select = 2'd3;
        else if (is_load)
            rd_select = 2'd2;
        else if (is_slt)
            rd_select = 2'd1;
    end

    always_comb begin
        be_base = '0;
        case (funct3[1:0])
            2'b00:   be_base[0]   = 1'b1;
            2'b01:   be_base[1:0] = 2'b11;
            default: be_base      = '1;
        endcase
    end

    assign mem_byte_enable = be_base << q[1:0];
    assign misaligned      = (funct3[1:0] == 2'b01 && q[0]) || (funct3[1] && q[1:0] != 2'b00);

    always_comb begin
        case (funct3)
            3'b000:  taken = equal_comp;
            3'b001:  taken = !equal_comp;
            3'b100:  taken = less_comp;
            3'b101:  taken = !less_comp;
            3'b110:  taken = less_comp;
            3'b111:  taken = !less_comp;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = '0;
        compute_valid_d = (state_q == S_DONE) || (state_q == S_TRAP);
        branch_flag_d   = branch_flag_q;
        new_pc_d        = new_pc_q;
        fault_d         = fault_q;
        fault_cause_d   = fault_cause_q;
        mv_first_d      = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        rf_enable       = 1'b0;
        select_imm      = 1'b0;
        select_pc       = 1'b0;
        zero_rs1        = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (compute_req)
                    state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                fault_d       = 1'b0;
                fault_cause_d = 2'd0;
                branch_flag_d = 1'b0;
                rf_enable     = writes_rf;
                select_imm    = uses_imm;
                select_pc     = is_auipc;
                zero_rs1      = is_lui;
                if (is_illegal) begin
                    state_d       = S_TRAP;
                    fault_d       = 1'b1;
                    fault_cause_d = 2'd1;
                end else if (is_load || is_store) begin
                    if (misaligned) begin
                        state_d       = S_TRAP;
                        fault_d       = 1'b1;
                        fault_cause_d = 2'd2;
                    end else begin
                        state_d = S_MEM_REQ;
                    end
                end else if (is_branch) begin
                    branch_flag_d = taken;
                    state_d       = S_PC_UPDATE;
                end else if (is_jal || is_jalr) begin
                    branch_flag_d = 1'b1;
                    state_d       = S_PC_UPDATE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_PC_UPDATE: begin
                select_imm = 1'b1;
                select_pc  = !is_jalr;
                new_pc_d   = is_jalr ? {q[DATA_WIDTH-1:1], 1'b0} : q;
                state_d    = S_DONE;
            end
            S_MEM_REQ: begin
                // Operand B stays on imm so q keeps presenting the address for the lane mask.
                mem_req    = 1'b1;
                mem_we     = is_store;
                select_imm = 1'b1;
                if (mem_valid) begin
                    state_d    = S_MEM_VALID;
                    mv_first_d = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = S_TRAP;
                    fault_d       = 1'b1;
                    fault_cause_d = 2'd3;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_MEM_VALID: begin
                select_imm = 1'b1;
                rf_enable  = is_load && mv_first_q;
                if (!mem_valid)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (!compute_req)
                    state_d = S_WAIT;
            end
            S_TRAP: begin
                branch_flag_d = 1'b0;
                if (!compute_req)
                    state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_WAIT;
            cnt_q           <= '0;
            compute_valid_q <= 1'b0;
            branch_flag_q   <= 1'b0;
            new_pc_q        <= '0;
            fault_q         <= 1'b0;
            fault_cause_q   <= 2'd0;
            mv_first_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            compute_valid_q <= compute_valid_d;
            branch_flag_q   <= branch_flag_d;
            new_pc_q        <= new_pc_d;
            fault_q         <= fault_d;
            fault_cause_q   <= fault_cause_d;
            mv_first_q      <= mv_first_d;
        end
    end

    assign compute_valid = compute_valid_q;
    assign branch_flag   = branch_flag_q;
    assign new_pc        = new_pc_q;
    assign fault         = fault_q;
    assign fault_cause   = fault_cause_q;

endmodule

// File: doc/decode_seq.md
Name: decode_seq

Overview:
- Second-generation instruction decode and sequencing unit for the RV32I core.
- Sits between fetch, register file, ALU and LSU.
- Decodes one instruction per fetch handshake, sequences ALU, memory and PC-update phases, and drives writeback control.
- New versus the current decoder:
  - unsigned compares and arithmetic shift/SUB selection
  - LUI/AUIPC/JALR support and link writeback
  - lane-shifted byte enables with load zero-extension
  - misaligned-access and illegal-opcode traps
  - LSU timeout

Parameters:
- DATA_WIDTH, 32, datapath width.
- ALU_CONTROL_BITS, 3, ALU opcode width; encodings ADD_SUB_OP, LLS_OP, RLS_OP, XOR_OP, OR_OP, AND_OP from config.v.
- LOG2_REGISTERS, 5, register address width.
- BYTE_DATA_WIDTH, 4, byte lanes (DATA_WIDTH/8).
- MEM_TIMEOUT, 16, max cycles in MEM_REQ before trap; valid range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- inst  in  DATA_WIDTH  instruction, stable while compute_req high.
- compute_req  in  1  fetch request.
- compute_valid  out  1  instruction retired (registered).
- branch_flag  out  1  take new_pc (registered).
- new_pc  out  DATA_WIDTH  jump/branch target (registered).
- mem_req  out  1  LSU request.
- mem_we  out  1  store.
- mem_valid  in  1  LSU response.
- mem_byte_enable  out  BYTE_DATA_WIDTH  lane mask, shifted by q[1:0].
- load_unsigned  out  1  zero-extend load data (LBU/LHU).
- addr_rd / addr_rs1 / addr_rs2  out  LOG2_REGISTERS each  inst[11:7] / inst[19:15] / inst[24:20].
- zero_rs1  out  1  force ALU operand A to 0 (LUI).
- rd_select  out  2  writeback source: 0 ALU, 1 direct_store, 2 memory, 3 pc+4.
- rf_enable  out  1  register write strobe.
- direct_store  out  DATA_WIDTH  SLT* result, {31'b0, less_comp}.
- less_comp, equal_comp  in  1 each  ALU compare results.
- alu_control  out  ALU_CONTROL_BITS  ALU opcode.
- alt_flag  out  1  SUB (R-type funct7=0100000) or SRA/SRAI.
- unsigned_flag  out  1  unsigned compare: SLTU, SLTIU, BLTU, BGEU.
- imm  out  DATA_WIDTH  sign-extended I/S/B/J immediate, or U immediate {inst[31:12], 12'b0}.
- select_imm  out  1  ALU operand B = imm.
- select_pc  out  1  ALU operand A = pc.
- q  in  DATA_WIDTH  ALU result.
- fault  out  1  trap indication, valid with compute_valid.
- fault_cause  out  2  0 none, 1 illegal opcode, 2 misaligned, 3 LSU timeout.

Behaviour:
- Reset (rst=0 at posedge):
  - state goes to WAIT and the timeout counter clears.
  - compute_valid, branch_flag, new_pc, fault and fault_cause all go to 0.
  - Combinational strobes (mem_req, rf_enable, select_*) are 0 in WAIT.
  - Reset mid-operation abandons the instruction; mem_req drops the next cycle.
- Decode is combinational from inst in every state.
- Unsupported opcodes (including SYSTEM 1110011) are illegal.
- FSM states: WAIT, COMPUTE, PC_UPDATE, MEM_REQ, MEM_VALID, DONE, TRAP.
- WAIT: compute_req=1 goes to COMPUTE.
- COMPUTE:
  - Illegal opcode goes to TRAP, cause 1.
  - Load/store with misaligned q goes to TRAP, cause 2. Misaligned means half with q[0]=1, or word with q[1:0]!=0.
  - Otherwise load/store goes to MEM_REQ.
  - Branch/JAL/JALR goes to PC_UPDATE.
  - Everything else goes to DONE.
  - select_imm=1 for OP-IMM, load, store, LUI, AUIPC.
  - AUIPC: select_pc=1.
  - LUI: zero_rs1=1.
  - rf_enable=1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR (rd_select=3 for JAL/JALR).
  - branch_flag is registered: compare result for branches, 1 for JAL/JALR.
- PC_UPDATE:
  - Branch/JAL: select_pc=1, select_imm=1.
  - JALR: select_imm=1 only.
  - new_pc <= q, with q[0] forced to 0 for JALR.
  - Next state DONE.
- MEM_REQ:
  - mem_req=1; mem_we=1 for stores.
  - Counter increments each cycle.
  - mem_valid=1 goes to MEM_VALID and clears the counter.
  - Counter reaching MEM_TIMEOUT with mem_valid=0 goes to TRAP, cause 3; mem_req deasserts the same edge.
  - mem_valid in the same cycle as timeout: mem_valid wins.
- MEM_VALID:
  - Loads: rf_enable=1 and rd_select=2 for the first cycle only.
  - Stay while mem_valid=1; go to DONE when it drops.
- DONE:
  - compute_valid=1 (registered, visible the cycle after entry).
  - Return to WAIT when compute_req=0.
- TRAP:
  - fault=1, compute_valid=1, fault_cause held, branch_flag cleared; rf_enable never asserted.
  - Return to WAIT when compute_req=0.
  - fault and fault_cause clear on the next instruction's COMPUTE.
- Latency from compute_req: ALU op 3 cycles to compute_valid; branch 4 cycles; load/store 5 cycles plus LSU wait.
- Byte enables: base mask is 0001 / 0011 / 1111 for byte / half / word, shifted left by q[1:0].
- Branches: BGE/BGEU take when ~less_comp.

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093) -> imm=0xFFFFFFFB, select_imm=1, rf_enable pulse, compute_valid high 3 cycles after compute_req.
- SRA (funct7=0100000) -> alu_control=RLS_OP, alt_flag=1; BLTU with less_comp=1 -> unsigned_flag=1, branch_flag=1.
- JALR with q=0x1003 -> new_pc=0x1002, rd_select=3 with rf_enable in COMPUTE, branch_flag=1.
- SB with q=0x...2 -> mem_byte_enable=0100, mem_we=1; LH with q=0x...1 -> fault=1, cause 2, no mem_req, no rf_enable.
- LW with mem_valid held low (MEM_TIMEOUT=16) -> mem_req for 16 cycles, then fault with cause 3; LBU -> load_unsigned=1.
- Opcode 0x7F -> fault cause 1; rst low during MEM_REQ -> mem_req=0 next cycle, all outputs 0.
